fetch_stage: RTL and testbench

//  IF stage of the 5-stage pipelined CPU.
//  - Owns the PC and drives the synchronous instruction memory (1-cycle read latency).
//  - Buffers fetched words in a small FIFO and presents them to decode (ID) with valid/ready.
//  - Absorbs branch/jump redirects from EX.
//  - Supports 32-bit instructions only.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 79 +++++++
 rtl/fetch_stage.sv | 103 ++++++++++
 tb/tb_fetch_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Types and constants shared by the fetch stage and its fetch buffer.
//   FETCH_ADDR_W  : PC width in bits that the fetch_entry_t layout is built for
//   NOP_INSTR     : word presented to decode whenever no instruction is valid
//   fetch_entry_t : one buffered fetch result {pc, instr}
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int          FETCH_ADDR_W = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h4000_0009;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [31:0]             instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// DEPTH-entry circular buffer of fetch_entry_t between the instruction memory
// response and the decode stage.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   push     : write din at the tail
//   pop      : drop the head entry (ignored when empty)
//   flush    : discard all entries; has priority over push and pop
//   din      : entry to write
//   count    : number of valid entries
//   head     : oldest entry (undefined contents while count == 0)
// -----------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap explicitly so non-power-of-two depths also work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop && (count != '0);
  // A full buffer can still accept a write when the head leaves in the same
  // cycle: the freed slot is the one being written.
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  // NOTE: the storage array has no reset; validity is tracked by count alone,
  // which keeps the data path free of reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  // NOTE: all sequential state is updated with non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// IF stage of the 5-stage pipeline. Owns the PC, drives the synchronous
// instruction memory (1-cycle read latency), buffers returned words and hands
// them to decode with a valid/ready handshake. Redirects from EX flush the
// buffer and kill any outstanding memory read.
// Parameters:
//   ADDR_W   : PC width (must equal fetch_pkg::FETCH_ADDR_W)
//   IM_AW    : instruction-memory word-address width
//   DEPTH    : fetch-buffer entries (>= 2 for one instruction per cycle)
//   RESET_PC : PC loaded on reset
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   redirect_valid, redirect_pc : PC change request from EX (low 2 bits ignored)
//   im_en, im_addr              : IM read request (combinational)
//   im_rdata                    : IM read data, valid the cycle after im_en
//   id_valid, id_ready          : decode handshake
//   id_instr, id_pc             : head instruction and its PC (NOP / 0 when idle)
// -----------------------------------------------------------------------------
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                IM_AW    = 14,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              im_en,
  output logic [IM_AW-1:0]  im_addr,
  input  logic [31:0]       im_rdata,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       id_instr,
  output logic [ADDR_W-1:0] id_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic [CW-1:0]     count;
  logic [CW:0]       occupancy;
  logic              pop;
  logic              push;
  logic              issue;
  fetch_entry_t      head;
  fetch_entry_t      resp;

  assign id_valid  = (count != '0);
  assign pop       = id_valid & id_ready;

  // Buffered entries plus the outstanding read. Issuing only while this is
  // below DEPTH (or a slot frees this cycle) guarantees the response always
  // has room, so no back-pressure on the memory side is needed.
  assign occupancy = {1'b0, count} + (CW + 1)'(inflight);
  assign issue     = !redirect_valid && ((occupancy < (CW + 1)'(DEPTH)) || pop);

  assign im_en     = issue;
  assign im_addr   = pc[IM_AW+1:2];

  // A redirect in the response cycle kills the returning word.
  assign push      = inflight && !redirect_valid;
  assign resp      = '{pc: inflight_pc, instr: im_rdata};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (resp),
    .count (count),
    .head  (head)
  );

  assign id_instr = id_valid ? head.instr : NOP_INSTR;
  assign id_pc    = id_valid ? head.pc    : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      pc       <= {redirect_pc[ADDR_W-1:2], 2'b00};
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc          <= pc + ADDR_W'(4);
        inflight_pc <= pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage. A behavioural IM returns
// 32'h1000_0000 + word_index. Expected {pc, instr} pairs are queued when a
// stream starts (reset release or redirect) and popped on every accepted
// handshake. A second instance checks the PC wrap from RESET_PC=FFFF_FFF8.
// -----------------------------------------------------------------------------
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int ADDR_W = 32;
  localparam int IM_AW  = 14;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              im_en;
  logic [IM_AW-1:0]  im_addr;
  logic [31:0]       im_rdata;
  logic              id_valid;
  logic              id_ready;
  logic [31:0]       id_instr;
  logic [ADDR_W-1:0] id_pc;

  logic              rst_b;
  logic              im_en_b;
  logic [IM_AW-1:0]  im_addr_b;
  logic [31:0]       im_rdata_b;
  logic              id_valid_b;
  logic [31:0]       id_instr_b;
  logic [ADDR_W-1:0] id_pc_b;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  fetch_entry_t sb[$];

  always #5 clk = ~clk;

  fetch_stage #(
    .ADDR_W(ADDR_W), .IM_AW(IM_AW), .DEPTH(DEPTH), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .im_en(im_en), .im_addr(im_addr), .im_rdata(im_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
  );

  fetch_stage #(
    .ADDR_W(ADDR_W), .IM_AW(IM_AW), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)
  ) dut_b (
    .clk(clk), .rst(rst_b), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .im_en(im_en_b), .im_addr(im_addr_b), .im_rdata(im_rdata_b),
    .id_valid(id_valid_b), .id_ready(1'b1), .id_instr(id_instr_b), .id_pc(id_pc_b)
  );

  function automatic logic [31:0] im_word(input logic [IM_AW-1:0] a);
    return 32'h1000_0000 + {{(32-IM_AW){1'b0}}, a};
  endfunction

  // Synchronous instruction memories, one-cycle read latency.
  always @(posedge clk) if (im_en)   im_rdata   <= im_word(im_addr);
  always @(posedge clk) if (im_en_b) im_rdata_b <= im_word(im_addr_b);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_stream(input logic [ADDR_W-1:0] start, input int n);
    fetch_entry_t e;
    for (int i = 0; i < n; i++) begin
      e.pc    = start + ADDR_W'(4 * i);
      e.instr = im_word(e.pc[IM_AW+1:2]);
      sb.push_back(e);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then check any handshake.
  task automatic cyc(input logic rv, input logic [ADDR_W-1:0] rpc, input logic rdy);
    fetch_entry_t e;
    @(negedge clk);
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = rdy;
    #1;
    if (id_valid && id_ready) begin
      n_pops++;
      if (sb.size() == 0) begin
        check("sb_underflow", 64'(id_pc), 64'hDEAD);
      end else begin
        e = sb.pop_front();
        check("sb_pc", id_pc, e.pc);
        check("sb_instr", id_instr, e.instr);
      end
    end
    if (rv) begin
      sb.delete();
      push_stream({rpc[ADDR_W-1:2], 2'b00}, 64);
    end
  endtask

  // Release reset at a falling edge; the sample point that follows is cycle 0.
  task automatic release_rst();
    @(negedge clk);
    rst            = 1'b0;
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    sb.delete();
    push_stream(32'h0, 64);
    #1;
  endtask

  logic [31:0] wrap_pc    [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
  logic [31:0] wrap_instr [3] = '{32'h1000_3FFE, 32'h1000_3FFF, 32'h1000_0000};

  initial begin
    int p0;
    rst = 1'b1; rst_b = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", id_valid, 0);
    check("rst_instr", id_instr, NOP_INSTR);
    check("rst_pc",    id_pc,    0);

    // PC wrap from RESET_PC = FFFF_FFF8
    @(negedge clk);
    rst_b = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      #1;
      if (c == 1) begin
        check("wrap_c1_valid", id_valid_b, 0);
      end else begin
        check("wrap_valid", id_valid_b, 1);
        check("wrap_pc",    id_pc_b,    wrap_pc[c-2]);
        check("wrap_instr", id_instr_b, wrap_instr[c-2]);
      end
    end

    // Straight-line stream, decode always ready
    release_rst();
    check("c0_im_en",   im_en,    1);
    check("c0_im_addr", im_addr,  0);
    check("c0_valid",   id_valid, 0);
    cyc(1'b0, '0, 1'b1);
    check("c1_valid", id_valid, 0);
    for (int c = 2; c <= 9; c++) begin
      cyc(1'b0, '0, 1'b1);
      check("stream_valid", id_valid, 1);
    end

    // Reset asserted mid-stream takes effect without a clock edge
    #1 rst = 1'b1;
    #1;
    check("mid_rst_valid", id_valid, 0);
    check("mid_rst_instr", id_instr, NOP_INSTR);
    check("mid_rst_pc",    id_pc,    0);

    // Restart, with decode stalled in cycles 5..8
    release_rst();
    p0 = n_pops;
    check("restart_im_addr", im_addr, 0);
    for (int c = 1; c <= 20; c++) begin
      cyc(1'b0, '0, !(c >= 5 && c <= 8));
      if (c == 1) check("restart_c1_valid", id_valid, 0);
      if (c >= 5 && c <= 8) begin
        check("stall_valid", id_valid, 1);
        check("stall_pc",    id_pc,    32'd12);
        check("stall_instr", id_instr, 32'h1000_0003);
        check("stall_im_en", im_en,    0);
      end
      if (c == 9) check("unstall_im_en", im_en, 1);
    end
    check("stall_pops", n_pops - p0, 15);

    // Redirect to 0x40 while streaming (head consumed in the same cycle)
    cyc(1'b1, 32'h40, 1'b1);
    check("redir_im_en", im_en, 0);
    cyc(1'b0, '0, 1'b1);
    check("redir_n1_valid",   id_valid, 0);
    check("redir_n1_im_en",   im_en,    1);
    check("redir_n1_im_addr", im_addr,  16);
    cyc(1'b0, '0, 1'b1);
    check("redir_n2_valid", id_valid, 0);
    cyc(1'b0, '0, 1'b1);
    check("redir_n3_valid", id_valid, 1);
    check("redir_n3_pc",    id_pc,    32'h40);
    check("redir_n3_instr", id_instr, 32'h1000_0010);
    repeat (2) cyc(1'b0, '0, 1'b1);

    // Fill the buffer, then redirect to an unaligned target
    repeat (3) cyc(1'b0, '0, 1'b0);
    check("full_valid", id_valid, 1);
    check("full_im_en", im_en,    0);
    cyc(1'b1, 32'h43, 1'b0);
    check("unal_im_en", im_en, 0);
    cyc(1'b0, '0, 1'b1);
    check("unal_n1_valid",   id_valid, 0);
    check("unal_n1_im_addr", im_addr,  16);
    cyc(1'b0, '0, 1'b1);
    check("unal_n2_valid", id_valid, 0);
    cyc(1'b0, '0, 1'b1);
    check("unal_n3_pc", id_pc, 32'h40);
    repeat (2) cyc(1'b0, '0, 1'b1);

    // Back-to-back redirects: the second one wins
    cyc(1'b1, 32'h100, 1'b1);
    cyc(1'b1, 32'h200, 1'b1);
    check("b2b_valid", id_valid, 0);
    check("b2b_im_en", im_en,    0);
    cyc(1'b0, '0, 1'b1);
    check("b2b_n1_valid",   id_valid, 0);
    check("b2b_n1_im_addr", im_addr,  32'h80);
    cyc(1'b0, '0, 1'b1);
    check("b2b_n2_valid", id_valid, 0);
    cyc(1'b0, '0, 1'b1);
    check("b2b_n3_valid", id_valid, 1);
    check("b2b_n3_pc",    id_pc,    32'h200);
    repeat (4) cyc(1'b0, '0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
